seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 141 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Multiplexed four-digit seven-segment scan controller.
// Cycles through the digits (DIV drive cycles + DEAD blanking cycles per digit),
// and double-buffers incoming digit codes so a frame is never torn.
module seg_scan_ctrl #(
    parameter int unsigned DIV  = 1000,
    parameter int unsigned DEAD = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [11:0] din,
    input  logic        wr,
    output logic        ack,
    output logic [2:0]  code,
    output logic [3:0]  an,
    output logic        frame
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned DIG_W  = 3;
    localparam int unsigned DATA_W = 4 * DIG_W;

    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(DEAD - 1);
    localparam bit               NO_BLANK   = (DEAD == 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        BLANK = 2'd2
    } state_t;

    // Held as a raw vector so the unused code 2'd3 stays representable and recoverable.
    logic [1:0]        state;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] stg;
    logic [DATA_W-1:0] disp;
    logic              pend;
    logic              frame_hit;
    logic              commit;

    // Last cycle of the digit-3 slot: final BLANK cycle, or final DRIVE cycle without blanking.
    always_comb begin
        frame_hit = 1'b0;
        if (idx == IDX_W'(3)) begin
            if (NO_BLANK) begin
                frame_hit = (state == DRIVE) && (cnt == DRIVE_LAST);
            end else begin
                frame_hit = (state == BLANK) && (cnt == BLANK_LAST);
            end
        end
    end

    assign commit = pend && ((state == IDLE) || frame_hit);
    assign frame  = frame_hit;

    // Digit enable and code decode from the state/index/display registers.
    always_comb begin
        an   = 4'b1111;
        code = 3'b000;
        if (state == DRIVE) begin
            an = ~(4'b0001 << idx);
            case (idx)
                2'd0:    code = disp[2:0];
                2'd1:    code = disp[5:3];
                2'd2:    code = disp[8:6];
                default: code = disp[11:9];
            endcase
        end
    end

    // Scan FSM: slot timing with a prescaler shared between drive and blank phases.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else if (!en) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= DRIVE;
                    idx   <= '0;
                    cnt   <= '0;
                end
                DRIVE: begin
                    if (cnt == DRIVE_LAST) begin
                        cnt <= '0;
                        if (NO_BLANK) begin
                            idx <= idx + IDX_W'(1);
                        end else begin
                            state <= BLANK;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        cnt   <= '0;
                        idx   <= idx + IDX_W'(1);
                        state <= DRIVE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Staging buffer: writes land in stg, move to disp only at a frame boundary or while idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stg  <= '0;
            disp <= '0;
            pend <= 1'b0;
            ack  <= 1'b0;
        end else begin
            ack <= commit;
            if (commit) begin
                disp <= stg;
                pend <= 1'b0;
            end
            if (wr) begin
                stg  <= din;
                pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: two instances (with and without blanking) checked
// every cycle against a slot-arithmetic model, plus directed literal checks.
module tb_seg_scan_ctrl;

    localparam int unsigned NI    = 2;
    localparam int unsigned DIV0  = 4;
    localparam int unsigned DEAD0 = 2;
    localparam int unsigned DIV1  = 3;
    localparam int unsigned DEAD1 = 0;

    logic        clk = 1'b0;
    logic        rst_n, en, wr;
    logic [11:0] din;
    logic        ack0, frame0, ack1, frame1;
    logic [2:0]  code0, code1;
    logic [3:0]  an0, an1;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.DIV(DIV0), .DEAD(DEAD0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .wr(wr),
        .ack(ack0), .code(code0), .an(an0), .frame(frame0)
    );

    seg_scan_ctrl #(.DIV(DIV1), .DEAD(DEAD1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .wr(wr),
        .ack(ack1), .code(code1), .an(an1), .frame(frame1)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 0;

    // Model: scanning flag plus elapsed cycles since scan start; all outputs follow by arithmetic.
    int          m_div  [NI];
    int          m_dead [NI];
    bit          m_scan [NI];
    bit          m_ill  [NI];
    int          m_t    [NI];
    logic [11:0] m_disp [NI];
    logic [11:0] m_stg  [NI];
    bit          m_pend [NI];
    bit          m_ack  [NI];

    function automatic bit exp_frame(int i);
        int p4;
        p4 = 4 * (m_div[i] + m_dead[i]);
        return !m_ill[i] && m_scan[i] && ((m_t[i] % p4) == p4 - 1);
    endfunction

    function automatic bit exp_drive(int i);
        int sl;
        sl = m_div[i] + m_dead[i];
        return !m_ill[i] && m_scan[i] && ((m_t[i] % sl) < m_div[i]);
    endfunction

    function automatic int exp_digit(int i);
        return (m_t[i] / (m_div[i] + m_dead[i])) % 4;
    endfunction

    function automatic logic [3:0] exp_an(int i);
        if (!exp_drive(i)) return 4'hF;
        return 4'hF ^ (4'h1 << exp_digit(i));
    endfunction

    function automatic logic [2:0] exp_code(int i);
        if (!exp_drive(i)) return 3'd0;
        return 3'(m_disp[i] >> (3 * exp_digit(i)));
    endfunction

    task automatic check(input string name, input int inst,
                         input logic [11:0] got, input logic [11:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, inst, got, exp, $time);
        end
    endtask

    // Model update on each rising edge from the inputs the bench is driving.
    always @(posedge clk) begin : model_upd
        bit fr, cm;
        for (int i = 0; i < int'(NI); i++) begin
            if (!rst_n) begin
                m_scan[i] = 0; m_ill[i] = 0; m_t[i] = 0;
                m_disp[i] = '0; m_stg[i] = '0; m_pend[i] = 0; m_ack[i] = 0;
            end else begin
                fr = exp_frame(i);
                cm = m_pend[i] && ((!m_scan[i] && !m_ill[i]) || fr);
                m_ack[i] = cm;
                if (cm) begin
                    m_disp[i] = m_stg[i];
                    m_pend[i] = 0;
                end
                if (wr) begin
                    m_stg[i]  = din;
                    m_pend[i] = 1;
                end
                if (m_ill[i] || !en) begin
                    m_scan[i] = 0; m_t[i] = 0; m_ill[i] = 0;
                end else if (!m_scan[i]) begin
                    m_scan[i] = 1; m_t[i] = 0;
                end else begin
                    m_t[i]++;
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < int'(NI); i++) begin
                check("an",    i, 12'(i == 0 ? an0    : an1),    12'(exp_an(i)));
                check("code",  i, 12'(i == 0 ? code0  : code1),  12'(exp_code(i)));
                check("frame", i, 12'(i == 0 ? frame0 : frame1), 12'(exp_frame(i)));
                check("ack",   i, 12'(i == 0 ? ack0   : ack1),   12'(m_ack[i]));
            end
        end
    end

    initial begin
        m_div[0] = DIV0; m_dead[0] = DEAD0;
        m_div[1] = DIV1; m_dead[1] = DEAD1;
        rst_n = 1'b0; en = 1'b0; wr = 1'b0; din = '0;
        repeat (2) @(negedge clk);
        chk_on = 1;
        check("rst_an", 0, 12'(an0), 12'hF);
        check("rst_code", 0, 12'(code0), 12'h0);
        check("rst_ack", 0, 12'(ack0), 12'h0);
        check("rst_frame", 0, 12'(frame0), 12'h0);
        rst_n = 1'b1;

        // Write while idle: commit on the edge after capture.
        wr = 1'b1; din = 12'o7531;
        @(negedge clk); wr = 1'b0;
        check("idle_ack_pre", 0, 12'(ack0), 12'h0);
        @(negedge clk);
        check("idle_ack", 0, 12'(ack0), 12'h1);
        check("idle_an", 0, 12'(an0), 12'hF);
        @(negedge clk);
        check("idle_ack_post", 0, 12'(ack0), 12'h0);

        // Enable: hand-computed scan pattern for digits 1,3,5,7.
        en = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 24; k++) begin
            case (k)
                0: begin
                    check("k0_an", 0, 12'(an0), 12'hE);
                    check("k0_code", 0, 12'(code0), 12'd1);
                    check("k0_an_nb", 1, 12'(an1), 12'hE);
                end
                3:  check("k3_an_nb", 1, 12'(an1), 12'hD);
                4:  check("k4_an", 0, 12'(an0), 12'hF);
                6: begin
                    check("k6_an", 0, 12'(an0), 12'hD);
                    check("k6_code", 0, 12'(code0), 12'd3);
                end
                11: check("k11_frame_nb", 1, 12'(frame1), 12'h1);
                12: begin
                    check("k12_an", 0, 12'(an0), 12'hB);
                    check("k12_code", 0, 12'(code0), 12'd5);
                end
                18: begin
                    check("k18_an", 0, 12'(an0), 12'h7);
                    check("k18_code", 0, 12'(code0), 12'd7);
                end
                22: check("k22_frame", 0, 12'(frame0), 12'h0);
                23: begin
                    check("k23_frame", 0, 12'(frame0), 12'h1);
                    check("k23_an", 0, 12'(an0), 12'hF);
                end
                default: ;
            endcase
            @(negedge clk);
        end
        check("k24_an", 0, 12'(an0), 12'hE);
        check("k24_code", 0, 12'(code0), 12'd1);

        // Write mid digit 1; zeros appear only from the next frame.
        repeat (7) @(negedge clk);
        wr = 1'b1; din = 12'o0000;
        @(negedge clk); wr = 1'b0;
        repeat (16) @(negedge clk);
        check("zero_ack", 0, 12'(ack0), 12'h1);
        check("zero_code", 0, 12'(code0), 12'd0);
        check("zero_an", 0, 12'(an0), 12'hE);

        // Two writes, the second in the frame-pulse cycle.
        repeat (2) @(negedge clk);
        wr = 1'b1; din = 12'o1111;
        @(negedge clk); wr = 1'b0;
        repeat (20) @(negedge clk);
        check("pre_pulse_frame", 0, 12'(frame0), 12'h1);
        wr = 1'b1; din = 12'o2222;
        @(negedge clk); wr = 1'b0;
        check("dbl_ack1", 0, 12'(ack0), 12'h1);
        check("dbl_code1", 0, 12'(code0), 12'd1);
        @(negedge clk);
        check("dbl_ack_gap", 0, 12'(ack0), 12'h0);
        repeat (23) @(negedge clk);
        check("dbl_ack2", 0, 12'(ack0), 12'h1);
        check("dbl_code2", 0, 12'(code0), 12'd2);

        // Drop enable during digit 2 drive, then restart from digit 0.
        repeat (13) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("dis_an", 0, 12'(an0), 12'hF);
        en = 1'b1;
        @(negedge clk);
        check("restart_an", 0, 12'(an0), 12'hE);
        check("restart_code", 0, 12'(code0), 12'd2);

        // Reset during the blank after digit 1.
        repeat (10) @(negedge clk);
        check("pre_rst_blank", 0, 12'(an0), 12'hF);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_an", 0, 12'(an0), 12'hF);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_an", 0, 12'(an0), 12'hE);
        check("post_rst_code", 0, 12'(code0), 12'd0);

        // Illegal state encoding: dark outputs, back to idle on the next edge.
        wr = 1'b1; din = 12'o6543;
        @(negedge clk); wr = 1'b0;
        @(posedge clk);
        #2;
        force dut0.state = 2'b11;
        m_ill[0] = 1;
        #1;
        release dut0.state;
        @(negedge clk);
        check("ill_an", 0, 12'(an0), 12'hF);
        check("ill_code", 0, 12'(code0), 12'h0);
        @(negedge clk);
        check("ill_idle_an", 0, 12'(an0), 12'hF);
        @(negedge clk);
        check("ill_restart_an", 0, 12'(an0), 12'hE);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            wr  = ($urandom_range(0, 15) == 0);
            din = 12'($urandom);
            if ($urandom_range(0, 199) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
            rst_n = ($urandom_range(0, 999) != 0);
            @(negedge clk);
        end

        chk_on = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
